// File: rtl/ex_stage.sv
// Execute stage of the 32-bit MIPS pipeline.
// The stage selects forwarded ALU operands and computes the ALU result with
// signed-overflow trapping, then registers everything into EX/MEM.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] ID_EX_rs_data,
  input  logic [WIDTH-1:0] ID_EX_rt_data,
  input  logic [WIDTH-1:0] ID_EX_imm,
  input  logic [4:0]       ID_EX_shamt,
  input  logic [3:0]       ID_EX_alu_op,
  input  logic             ID_EX_alu_src,
  input  logic             ID_EX_reg_write,
  input  logic             ID_EX_mem_read,
  input  logic             ID_EX_mem_write,
  input  logic             ID_EX_mem_to_reg,
  input  logic [4:0]       ID_EX_dest,
  input  logic [1:0]       fwd_A,
  input  logic [1:0]       fwd_B,
  input  logic [WIDTH-1:0] MEM_WB_data,
  output logic [WIDTH-1:0] EX_MEM_alu_result,
  output logic [WIDTH-1:0] EX_MEM_store_data,
  output logic [4:0]       EX_MEM_rd,
  output logic             EX_MEM_write,
  output logic             EX_MEM_mem_read,
  output logic             EX_MEM_mem_write,
  output logic             EX_MEM_mem_to_reg,
  output logic             EX_MEM_ovf
);

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpAddu = 4'h1,
    OpSub  = 4'h2,
    OpSubu = 4'h3,
    OpAnd  = 4'h4,
    OpOr   = 4'h5,
    OpXor  = 4'h6,
    OpNor  = 4'h7,
    OpSlt  = 4'h8,
    OpSltu = 4'h9,
    OpSll  = 4'hA,
    OpSrl  = 4'hB,
    OpSra  = 4'hC,
    OpLui  = 4'hD,
    OpSllv = 4'hE,
    OpSrav = 4'hF
  } alu_op_e;

  // EX/MEM pipeline register state
  logic [WIDTH-1:0] resultQ, storeQ;
  logic [4:0]       rdQ;
  logic             writeQ, memReadQ, memWriteQ, memToRegQ, ovfQ;

  // Next-state values computed from the current ID/EX contents
  logic [WIDTH-1:0] resultD, storeD;
  logic             writeD, memReadD, memWriteD, ovfD;

  logic [WIDTH-1:0] operandA, forwardB, operandB;
  logic [WIDTH-1:0] sumAB, diffAB;
  logic             addOvf, subOvf;
  alu_op_e          aluOp;

  assign aluOp = alu_op_e'(ID_EX_alu_op);

  // Operand forwarding: 10 reads the EX/MEM result register, 01 the write-back value, 00/11 the ID/EX operand
  always_comb begin
    operandA = ID_EX_rs_data;
    forwardB = ID_EX_rt_data;
    case (fwd_A)
      2'b10:   operandA = resultQ;
      2'b01:   operandA = MEM_WB_data;
      default: operandA = ID_EX_rs_data;
    endcase
    case (fwd_B)
      2'b10:   forwardB = resultQ;
      2'b01:   forwardB = MEM_WB_data;
      default: forwardB = ID_EX_rt_data;
    endcase
    operandB = ID_EX_alu_src ? ID_EX_imm : forwardB;
  end

  // Shared adder/subtractor and the signed-overflow detection for the trapping ops
  always_comb begin
    sumAB  = operandA + operandB;
    diffAB = operandA - operandB;
    addOvf = (operandA[WIDTH-1] == operandB[WIDTH-1]) && (sumAB[WIDTH-1] != operandA[WIDTH-1]);
    subOvf = (operandA[WIDTH-1] != operandB[WIDTH-1]) && (diffAB[WIDTH-1] != operandA[WIDTH-1]);
  end

  // ALU result selection and overflow-gated control for the EX/MEM D inputs
  always_comb begin
    resultD = '0;
    case (aluOp)
      OpAdd, OpAddu: resultD = sumAB;
      OpSub, OpSubu: resultD = diffAB;
      OpAnd:         resultD = operandA & operandB;
      OpOr:          resultD = operandA | operandB;
      OpXor:         resultD = operandA ^ operandB;
      OpNor:         resultD = ~(operandA | operandB);
      OpSlt:         resultD = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      OpSltu:        resultD = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
      OpSll:         resultD = operandB << ID_EX_shamt;
      OpSrl:         resultD = operandB >> ID_EX_shamt;
      OpSra:         resultD = $signed(operandB) >>> ID_EX_shamt;
      OpLui:         resultD = {operandB[15:0], 16'h0000};
      OpSllv:        resultD = operandB << operandA[4:0];
      OpSrav:        resultD = $signed(operandB) >>> operandA[4:0];
      default:       resultD = '0;
    endcase
    ovfD      = ((aluOp == OpAdd) && addOvf) || ((aluOp == OpSub) && subOvf);
    storeD    = forwardB;
    writeD    = ID_EX_reg_write && !ovfD;
    memReadD  = ID_EX_mem_read && !ovfD;
    memWriteD = ID_EX_mem_write && !ovfD;
  end

  // EX/MEM register: reset, then flush (bubble), then stall (hold), otherwise load
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      resultQ   <= '0;
      storeQ    <= '0;
      rdQ       <= '0;
      writeQ    <= 1'b0;
      memReadQ  <= 1'b0;
      memWriteQ <= 1'b0;
      memToRegQ <= 1'b0;
      ovfQ      <= 1'b0;
    end else if (!stall) begin
      resultQ   <= resultD;
      storeQ    <= storeD;
      rdQ       <= ID_EX_dest;
      writeQ    <= writeD;
      memReadQ  <= memReadD;
      memWriteQ <= memWriteD;
      memToRegQ <= ID_EX_mem_to_reg;
      ovfQ      <= ovfD;
    end
  end

  assign EX_MEM_alu_result = resultQ;
  assign EX_MEM_store_data = storeQ;
  assign EX_MEM_rd         = rdQ;
  assign EX_MEM_write      = writeQ;
  assign EX_MEM_mem_read   = memReadQ;
  assign EX_MEM_mem_write  = memWriteQ;
  assign EX_MEM_mem_to_reg = memToRegQ;
  assign EX_MEM_ovf        = ovfQ;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed cases with literal expectations plus a
// randomized run checked every cycle against an arithmetic reference model.
module tb_ex_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic [31:0] rsData, rtData, imm, memWbData;
  logic [4:0]  shamt, dest;
  logic [3:0]  aluOp;
  logic        aluSrc, regWrite, memRead, memWrite, memToReg;
  logic [1:0]  fwdA, fwdB;
  logic [31:0] exResult, exStore;
  logic [4:0]  exRd;
  logic        exWrite, exMemRead, exMemWrite, exMemToReg, exOvf;

  int assertCount = 0;
  int failCount   = 0;
  logic checkEnable = 1'b0;

  // Reference model state: what the EX/MEM register must hold
  logic [31:0] mResult, mStore;
  logic [4:0]  mRd;
  logic        mWrite, mMemRead, mMemWrite, mMemToReg, mOvf;

  typedef struct {
    logic [31:0] rs, rt, imm, mwb;
    logic [4:0]  shamt, dest;
    logic [3:0]  op;
    logic [1:0]  fa, fb;
    logic        aluSrc, regWrite, memRead, memWrite, memToReg;
    logic        stall, flush, reset;
  } stim_t;

  ex_stage #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .ID_EX_rs_data(rsData),
    .ID_EX_rt_data(rtData),
    .ID_EX_imm(imm),
    .ID_EX_shamt(shamt),
    .ID_EX_alu_op(aluOp),
    .ID_EX_alu_src(aluSrc),
    .ID_EX_reg_write(regWrite),
    .ID_EX_mem_read(memRead),
    .ID_EX_mem_write(memWrite),
    .ID_EX_mem_to_reg(memToReg),
    .ID_EX_dest(dest),
    .fwd_A(fwdA),
    .fwd_B(fwdB),
    .MEM_WB_data(memWbData),
    .EX_MEM_alu_result(exResult),
    .EX_MEM_store_data(exStore),
    .EX_MEM_rd(exRd),
    .EX_MEM_write(exWrite),
    .EX_MEM_mem_read(exMemRead),
    .EX_MEM_mem_write(exMemWrite),
    .EX_MEM_mem_to_reg(exMemToReg),
    .EX_MEM_ovf(exOvf)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pick a forwarded operand the way the pipeline defines it: 10 = EX/MEM, 01 = MEM/WB, else register file
  function automatic logic [31:0] pickForward(input logic [1:0] sel, input logic [31:0] regVal,
                                              input logic [31:0] exMemVal, input logic [31:0] wbVal);
    if (sel == 2'b10) return exMemVal;
    if (sel == 2'b01) return wbVal;
    return regVal;
  endfunction

  // ALU behaviour expressed with wide signed integer arithmetic
  function automatic logic [31:0] modelAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
    longint sa, sb, tmp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'h0, 4'h1: tmp = sa + sb;
      4'h2, 4'h3: tmp = sa - sb;
      4'h4: tmp = longint'(a & b);
      4'h5: tmp = longint'(a | b);
      4'h6: tmp = longint'(a ^ b);
      4'h7: tmp = longint'(~(a | b));
      4'h8: tmp = (sa < sb) ? 1 : 0;
      4'h9: tmp = (longint'(a) < longint'(b)) ? 1 : 0;
      4'hA: tmp = longint'(b) * (longint'(1) << sh);
      4'hB: tmp = longint'(b) / (longint'(1) << sh);
      4'hC: tmp = sb >>> sh;
      4'hD: tmp = longint'(b % 65536) * 65536;
      4'hE: tmp = longint'(b) * (longint'(1) << a[4:0]);
      default: tmp = sb >>> a[4:0];
    endcase
    return tmp[31:0];
  endfunction

  // A trapping op overflows when the exact signed result leaves the 32-bit range
  function automatic logic modelOvf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint exact;
    if (op == 4'h0) exact = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'h2) exact = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
  endfunction

  // Reference model of the EX/MEM register, advanced on every rising edge
  always @(posedge clk) begin
    logic [31:0] a, bf, b, r;
    logic        o;
    a  = pickForward(fwdA, rsData, mResult, memWbData);
    bf = pickForward(fwdB, rtData, mResult, memWbData);
    b  = aluSrc ? imm : bf;
    r  = modelAlu(aluOp, a, b, shamt);
    o  = modelOvf(aluOp, a, b);
    if (reset || flush) begin
      mResult <= 32'h0; mStore <= 32'h0; mRd <= 5'd0;
      mWrite <= 1'b0; mMemRead <= 1'b0; mMemWrite <= 1'b0; mMemToReg <= 1'b0; mOvf <= 1'b0;
    end else if (!stall) begin
      mResult   <= r;
      mStore    <= bf;
      mRd       <= dest;
      mWrite    <= regWrite & ~o;
      mMemRead  <= memRead & ~o;
      mMemWrite <= memWrite & ~o;
      mMemToReg <= memToReg;
      mOvf      <= o;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("model result", exResult, mResult);
      checkOutput("model store", exStore, mStore);
      checkOutput("model rd", {27'd0, exRd}, {27'd0, mRd});
      checkOutput("model write", {31'd0, exWrite}, {31'd0, mWrite});
      checkOutput("model mem_read", {31'd0, exMemRead}, {31'd0, mMemRead});
      checkOutput("model mem_write", {31'd0, exMemWrite}, {31'd0, mMemWrite});
      checkOutput("model mem_to_reg", {31'd0, exMemToReg}, {31'd0, mMemToReg});
      checkOutput("model ovf", {31'd0, exOvf}, {31'd0, mOvf});
    end
  end

  function automatic stim_t defaultStim();
    stim_t s;
    s.rs = 32'h0; s.rt = 32'h0; s.imm = 32'h0; s.mwb = 32'h0;
    s.shamt = 5'd0; s.dest = 5'd8; s.op = 4'h1; s.fa = 2'b00; s.fb = 2'b00;
    s.aluSrc = 1'b0; s.regWrite = 1'b1; s.memRead = 1'b0; s.memWrite = 1'b0; s.memToReg = 1'b0;
    s.stall = 1'b0; s.flush = 1'b0; s.reset = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] pickValue();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h00000001;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t randomStim();
    stim_t s;
    s.rs = pickValue(); s.rt = pickValue(); s.imm = pickValue(); s.mwb = pickValue();
    s.shamt = 5'($urandom_range(0, 31)); s.dest = 5'($urandom_range(0, 31));
    s.op = 4'($urandom_range(0, 15));
    s.fa = 2'($urandom_range(0, 3)); s.fb = 2'($urandom_range(0, 3));
    s.aluSrc = 1'($urandom_range(0, 1)); s.regWrite = 1'($urandom_range(0, 1));
    s.memRead = 1'($urandom_range(0, 1)); s.memWrite = 1'($urandom_range(0, 1));
    s.memToReg = 1'($urandom_range(0, 1));
    s.stall = ($urandom_range(0, 9) == 0); s.flush = ($urandom_range(0, 19) == 0);
    s.reset = ($urandom_range(0, 99) == 0);
    return s;
  endfunction

  // Drive one cycle of inputs away from the edge, then move to just after the next rising edge
  task automatic applyStimulus(input stim_t s);
    rsData = s.rs; rtData = s.rt; imm = s.imm; memWbData = s.mwb;
    shamt = s.shamt; dest = s.dest; aluOp = s.op; fwdA = s.fa; fwdB = s.fb;
    aluSrc = s.aluSrc; regWrite = s.regWrite; memRead = s.memRead; memWrite = s.memWrite;
    memToReg = s.memToReg; stall = s.stall; flush = s.flush; reset = s.reset;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " result"}, exResult, 32'h0);
    checkOutput({name, " store"}, exStore, 32'h0);
    checkOutput({name, " rd"}, {27'd0, exRd}, 32'h0);
    checkOutput({name, " ctrl"}, {27'd0, exWrite, exMemRead, exMemWrite, exMemToReg, exOvf}, 32'h0);
  endtask

  // Directed sequence followed by a randomized run
  initial begin
    stim_t s;
    s = defaultStim();
    s.reset = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    checkEnable = 1'b1;
    checkAllZero("reset");

    s = defaultStim(); s.op = 4'h0; s.rs = 32'h5; s.rt = 32'h7;
    applyStimulus(s);
    checkOutput("add result", exResult, 32'h0000000C);
    checkOutput("add rd", {27'd0, exRd}, 32'd8);
    checkOutput("add write/ovf", {30'd0, exWrite, exOvf}, 32'b10);

    s = defaultStim(); s.op = 4'h0; s.rs = 32'h8; s.rt = 32'h8;
    applyStimulus(s);
    checkOutput("fwd cycle1", exResult, 32'h00000010);
    s = defaultStim(); s.op = 4'h2; s.fa = 2'b10; s.rs = 32'h12345678; s.rt = 32'h3;
    applyStimulus(s);
    checkOutput("fwd A=10 sub", exResult, 32'h0000000D);
    s = defaultStim(); s.op = 4'h4; s.rs = 32'h0F0F0F0F; s.rt = 32'h0; s.fb = 2'b01; s.mwb = 32'hFFFFFFFF;
    applyStimulus(s);
    checkOutput("fwd B=01 and", exResult, 32'h0F0F0F0F);
    s = defaultStim(); s.op = 4'h1; s.fa = 2'b11; s.rs = 32'h55; s.mwb = 32'h1000;
    applyStimulus(s);
    checkOutput("fwd A=11", exResult, 32'h00000055);

    s = defaultStim(); s.op = 4'h0; s.rs = 32'h7FFFFFFF; s.rt = 32'h1; s.memRead = 1'b1;
    applyStimulus(s);
    checkOutput("ovf add result", exResult, 32'h80000000);
    checkOutput("ovf add flags", {29'd0, exOvf, exWrite, exMemRead}, 32'b100);
    s.op = 4'h1;
    applyStimulus(s);
    checkOutput("addu flags", {29'd0, exOvf, exWrite, exMemRead}, 32'b011);

    s = defaultStim(); s.op = 4'h0; s.rs = 32'h100; s.aluSrc = 1'b1; s.imm = 32'h4;
    s.fb = 2'b01; s.mwb = 32'hDEADBEEF; s.memWrite = 1'b1; s.regWrite = 1'b0;
    applyStimulus(s);
    checkOutput("store data", exStore, 32'hDEADBEEF);
    checkOutput("store addr", exResult, 32'h00000104);
    checkOutput("store mem_write", {31'd0, exMemWrite}, 32'd1);

    s = defaultStim(); s.op = 4'hC; s.rt = 32'h80000000; s.shamt = 5'd4;
    applyStimulus(s);
    checkOutput("sra", exResult, 32'hF8000000);
    s = defaultStim(); s.op = 4'h8; s.rs = 32'hFFFFFFFF; s.rt = 32'h1;
    applyStimulus(s);
    checkOutput("slt", exResult, 32'h1);
    s.op = 4'h9;
    applyStimulus(s);
    checkOutput("sltu", exResult, 32'h0);
    s = defaultStim(); s.op = 4'hD; s.aluSrc = 1'b1; s.imm = 32'h00001234;
    applyStimulus(s);
    checkOutput("lui", exResult, 32'h12340000);

    s = defaultStim(); s.op = 4'h0; s.rs = 32'h7FFFFFFF; s.rt = 32'h7FFFFFFF; s.dest = 5'd9;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = randomStim(); s.stall = 1'b1; s.flush = 1'b0; s.reset = 1'b0;
      applyStimulus(s);
      checkOutput("stall result", exResult, 32'hFFFFFFFE);
      checkOutput("stall rd/ovf", {26'd0, exRd, exOvf}, {26'd0, 5'd9, 1'b1});
    end
    s = defaultStim(); s.op = 4'h1; s.rs = 32'h1;
    applyStimulus(s);
    checkOutput("ovf cleared on load", {31'd0, exOvf}, 32'd0);

    s = randomStim(); s.stall = 1'b1; s.flush = 1'b1; s.reset = 1'b0;
    applyStimulus(s);
    checkAllZero("flush+stall");

    s = defaultStim(); s.rs = 32'hABCD; s.memToReg = 1'b1;
    applyStimulus(s);
    s = randomStim(); s.stall = 1'b1; s.flush = 1'b0; s.reset = 1'b1;
    applyStimulus(s);
    checkAllZero("reset in stall");

    s = defaultStim();
    applyStimulus(s);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randomStim());
    end

    checkEnable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
